// File: rtl/fft_r2_pkg.sv
// Shared types and helpers for the streaming radix-2 FFT engine.
// State encoding, bit reversal, saturation and twiddle unity.
package fft_r2_pkg;

   typedef enum logic [2:0] {
      LOAD   = 3'b001,
      PROC   = 3'b010,
      UNLOAD = 3'b100
   } state_t;

   // Wide enough for DW+2 bit butterfly sums up to DW=64
   localparam int SAT_W = 80;

   function automatic int tw_unity(input int tw);
      return (1 << (tw - 1)) - 1;
   endfunction

   function automatic logic [15:0] bitrev(input logic [15:0] v,
                                          input int bits);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         if (i < bits)
            r[4'(i)] = v[4'(bits - 1 - i)];
      return r;
   endfunction

   // Clamp to the symmetric range +/-(2^(dw-1)-1)
   function automatic logic signed [SAT_W-1:0] saturate(
      input logic signed [SAT_W-1:0] v,
      input int dw);
      logic signed [SAT_W-1:0] mx;
      mx = $signed((SAT_W'(1) << (dw - 1)) - SAT_W'(1));
      if (v > mx)
         return mx;
      else if (v < -mx)
         return -mx;
      return v;
   endfunction

endpackage

// File: rtl/fft_r2_twiddle_rom.sv
// Twiddle table W_k = cos - j*sin, k=0..N/2-1, scaled to unity.
// Contents are fixed at elaboration; lookup is combinational.
module fft_r2_twiddle_rom #(
   parameter int LOG2N = 10,
   parameter int TW    = 16
) (
   input  logic [LOG2N-2:0]     idx,
   output logic signed [TW-1:0] re,
   output logic signed [TW-1:0] im
);
   import fft_r2_pkg::*;

   localparam int H = 1 << (LOG2N - 1);
   localparam int N = 1 << LOG2N;

   function automatic logic signed [TW-1:0] tw_val(input int k,
                                                  input bit is_im);
      real a;
      real v;
      a = 6.283185307179586 * real'(k) / real'(N);
      v = is_im ? -$sin(a) : $cos(a);
      v = v * real'(tw_unity(TW));
      return TW'(v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v));
   endfunction

   logic signed [TW-1:0] rom_re [H];
   logic signed [TW-1:0] rom_im [H];

   for (genvar g = 0; g < H; g++) begin : g_rom
      assign rom_re[g] = tw_val(g, 1'b0);
      assign rom_im[g] = tw_val(g, 1'b1);
   end

   assign re = rom_re[idx];
   assign im = rom_im[idx];

endmodule

// File: rtl/fft_r2_stream.sv
// Streaming radix-2 DIT FFT/IFFT with in-place sample memory.
// Bit-reversed load, LOG2N butterfly passes, natural-order unload.
module fft_r2_stream #(
   parameter int LOG2N = 10,
   parameter int DW    = 32,
   parameter int TW    = 16,
   parameter int SCALE = 0
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_re,
   input  logic signed [DW-1:0] in_im,
   input  logic                 inverse,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out_re,
   output logic signed [DW-1:0] out_im,
   output logic                 out_last,
   output logic                 busy,
   output logic                 overflow
);
   import fft_r2_pkg::*;

   localparam int N  = 1 << LOG2N;
   localparam int AW = LOG2N;
   localparam int SW = DW + 2;
   localparam int MW = DW + TW + 1;

   state_t st;
   logic [AW-1:0] n_q, m_q;
   logic [3:0] pass_q;
   logic [AW-2:0] bfly_q;
   logic phase_q;
   logic inv_q;

   logic signed [DW-1:0] mem_re [N];
   logic signed [DW-1:0] mem_im [N];
   logic signed [DW-1:0] a_re, a_im, b_re, b_im;

   logic [AW-1:0] hmask, kk, top, bot, ld_addr;
   logic [AW-2:0] twi;
   logic signed [TW-1:0] tw_re, tw_im;
   logic ld_wr, rd_cyc, bf_wr;

   logic signed [MW-1:0] xr, xi, wr_e, wi_e, mr, mi;
   logic signed [SW-1:0] bpr, bpi;
   logic signed [SW-1:0] sum [4];
   logic signed [SAT_W-1:0] se [4];
   logic signed [SAT_W-1:0] ss [4];
   logic signed [DW-1:0] res [4];
   logic ovf;

   // Butterfly addressing: flat count b splits into block j and offset k
   always_comb begin
      hmask = AW'(1) << pass_q;
      kk = {1'b0, bfly_q} & (hmask - AW'(1));
      top = (({1'b0, bfly_q} & ~(hmask - AW'(1))) << 1) | kk;
      bot = top | hmask;
      twi = (AW-1)'(kk << (4'(LOG2N - 1) - pass_q));
      ld_addr = AW'(bitrev(16'(n_q), LOG2N));
      ld_wr = (st == LOAD) && in_valid && in_ready;
      rd_cyc = (st == PROC) && !phase_q;
      bf_wr = (st == PROC) && phase_q;
   end

   fft_r2_twiddle_rom #(
      .LOG2N(LOG2N),
      .TW   (TW)
   ) u_rom (
      .idx(twi),
      .re (tw_re),
      .im (tw_im)
   );

   // Complex multiply, add/subtract, optional scaling and saturation
   always_comb begin
      wr_e = MW'(tw_re);
      wi_e = inv_q ? -MW'(tw_im) : MW'(tw_im);
      xr = MW'(b_re);
      xi = MW'(b_im);
      mr = xr * wr_e - xi * wi_e;
      mi = xr * wi_e + xi * wr_e;
      if (twi == '0) begin
         bpr = SW'(b_re);
         bpi = SW'(b_im);
      end else begin
         bpr = SW'(mr >>> (TW - 1));
         bpi = SW'(mi >>> (TW - 1));
      end
      sum[0] = SW'(a_re) + bpr;
      sum[1] = SW'(a_im) + bpi;
      sum[2] = SW'(a_re) - bpr;
      sum[3] = SW'(a_im) - bpi;
      ovf = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (SCALE != 0)
            sum[c] = sum[c] >>> 1;
         se[c] = SAT_W'(sum[c]);
         ss[c] = saturate(se[c], DW);
         res[c] = DW'(ss[c]);
         ovf = ovf | (ss[c] != se[c]);
      end
   end

   // Sample memory and butterfly operand registers
   always_ff @(posedge Clk) begin
      if (ld_wr) begin
         mem_re[ld_addr] <= in_re;
         mem_im[ld_addr] <= in_im;
      end
      if (rd_cyc) begin
         a_re <= mem_re[top];
         a_im <= mem_im[top];
         b_re <= mem_re[bot];
         b_im <= mem_im[bot];
      end
      if (bf_wr) begin
         mem_re[top] <= res[0];
         mem_im[top] <= res[1];
         mem_re[bot] <= res[2];
         mem_im[bot] <= res[3];
      end
   end

   // Frame sequencer with registered handshake and status outputs
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         st <= LOAD;
         n_q <= '0;
         m_q <= '0;
         pass_q <= '0;
         bfly_q <= '0;
         phase_q <= 1'b0;
         inv_q <= 1'b0;
         in_ready <= 1'b1;
         out_valid <= 1'b0;
         out_last <= 1'b0;
         out_re <= '0;
         out_im <= '0;
         busy <= 1'b0;
         overflow <= 1'b0;
      end else begin
         unique case (st)
            LOAD: begin
               if (in_valid && in_ready) begin
                  if (n_q == '0) begin
                     inv_q <= inverse;
                     overflow <= 1'b0;
                  end
                  n_q <= n_q + AW'(1);
                  if (n_q == AW'(N - 1)) begin
                     st <= PROC;
                     in_ready <= 1'b0;
                     busy <= 1'b1;
                  end
               end
            end
            PROC: begin
               phase_q <= ~phase_q;
               if (phase_q) begin
                  overflow <= overflow | ovf;
                  if (bfly_q == '1) begin
                     bfly_q <= '0;
                     if (pass_q == 4'(LOG2N - 1)) begin
                        pass_q <= '0;
                        st <= UNLOAD;
                        busy <= 1'b0;
                        out_valid <= 1'b1;
                        out_last <= 1'b0;
                        out_re <= mem_re[0];
                        out_im <= mem_im[0];
                        m_q <= AW'(1);
                     end else begin
                        pass_q <= pass_q + 4'd1;
                     end
                  end else begin
                     bfly_q <= bfly_q + 1'b1;
                  end
               end
            end
            UNLOAD: begin
               if (out_valid && out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last <= 1'b0;
                     in_ready <= 1'b1;
                     m_q <= '0;
                     st <= LOAD;
                  end else begin
                     out_re <= mem_re[m_q];
                     out_im <= mem_im[m_q];
                     out_last <= (m_q == AW'(N - 1));
                     m_q <= m_q + AW'(1);
                  end
               end
            end
            default: st <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_r2_stream.sv
// Directed bench for fft_r2_stream at N=16: three instances in lockstep
// (DW=32 unscaled, DW=32 scaled, DW=16 unscaled) against a scoreboard.
module tb_fft_r2_stream;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   logic in_valid = 1'b0;
   logic signed [31:0] in_re = '0;
   logic signed [31:0] in_im = '0;
   logic inverse = 1'b0;
   logic out_ready = 1'b0;

   logic ir0, ir1, ir2;
   logic ov0, ov1, ov2;
   logic l0, l1, l2;
   logic bz0, bz1, bz2;
   logic of0, of1, of2;
   logic signed [31:0] r0, i0, r1, i1;
   logic signed [15:0] r2, i2;

   int checks = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   fft_r2_stream #(.LOG2N(4), .DW(32), .TW(16), .SCALE(0)) dut0 (
      .Clk(Clk), .Reset_n(Reset_n),
      .in_valid(in_valid), .in_ready(ir0),
      .in_re(in_re), .in_im(in_im), .inverse(inverse),
      .out_valid(ov0), .out_ready(out_ready),
      .out_re(r0), .out_im(i0), .out_last(l0),
      .busy(bz0), .overflow(of0));

   fft_r2_stream #(.LOG2N(4), .DW(32), .TW(16), .SCALE(1)) dut1 (
      .Clk(Clk), .Reset_n(Reset_n),
      .in_valid(in_valid), .in_ready(ir1),
      .in_re(in_re), .in_im(in_im), .inverse(inverse),
      .out_valid(ov1), .out_ready(out_ready),
      .out_re(r1), .out_im(i1), .out_last(l1),
      .busy(bz1), .overflow(of1));

   fft_r2_stream #(.LOG2N(4), .DW(16), .TW(16), .SCALE(0)) dut2 (
      .Clk(Clk), .Reset_n(Reset_n),
      .in_valid(in_valid), .in_ready(ir2),
      .in_re(in_re[15:0]), .in_im(in_im[15:0]), .inverse(inverse),
      .out_valid(ov2), .out_ready(out_ready),
      .out_re(r2), .out_im(i2), .out_last(l2),
      .busy(bz2), .overflow(of2));

   typedef struct {
      int er0, ei0, er1, ei1, er2, ei2;
      bit last;
   } exp_t;

   exp_t sb[$];
   int xr [16];
   int xi [16];
   int er [3][16];
   int ei [3][16];

   task automatic check(input string tag,
                        input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic fill_x(input int r, input int i);
      for (int n = 0; n < 16; n++) begin
         xr[n] = r;
         xi[n] = i;
      end
   endtask

   task automatic exp_all(input int k, input int r, input int i);
      for (int b = 0; b < 16; b++) begin
         er[k][b] = r;
         ei[k][b] = i;
      end
   endtask

   task automatic exp_push();
      exp_t e;
      for (int b = 0; b < 16; b++) begin
         e.er0 = er[0][b]; e.ei0 = ei[0][b];
         e.er1 = er[1][b]; e.ei1 = ei[1][b];
         e.er2 = er[2][b]; e.ei2 = ei[2][b];
         e.last = (b == 15);
         sb.push_back(e);
      end
   endtask

   task automatic load_frame(input bit inv, input bit gaps);
      int n = 0;
      int cyc = 0;
      while (n < 16 && cyc < 400) begin
         @(negedge Clk);
         cyc++;
         in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_re = xr[n];
         in_im = xi[n];
         inverse = inv;
         if (in_valid && ir0)
            n++;
      end
      @(negedge Clk);
      in_valid = 1'b0;
      check("load_count", n, 16);
      check("in_ready_drop", ir0, 0);
   endtask

   task automatic run_proc(input bit chk_len);
      int nb = 0;
      int cyc = 0;
      if (bz0) nb++;
      while (!ov0 && cyc < 2000) begin
         @(negedge Clk);
         cyc++;
         if (bz0) nb++;
      end
      check("unload_start", ov0, 1);
      if (chk_len)
         check("proc_cycles", nb, 64);
   endtask

   task automatic unload(input bit rnd);
      int got = 0;
      int cyc = 0;
      exp_t e;
      while (got < 16 && cyc < 1000) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (ov0) begin
            if (sb.size() == 0) begin
               check("extra_bin", 1, 0);
            end else begin
               e = sb[0];
               check($sformatf("b%0d_re0", got), r0, e.er0);
               check($sformatf("b%0d_im0", got), i0, e.ei0);
               check($sformatf("b%0d_re1", got), r1, e.er1);
               check($sformatf("b%0d_im1", got), i1, e.ei1);
               check($sformatf("b%0d_re2", got), r2, e.er2);
               check($sformatf("b%0d_im2", got), i2, e.ei2);
               check($sformatf("b%0d_last", got), l0, e.last);
               check($sformatf("b%0d_v12", got), {ov1, ov2}, 2'b11);
               if (out_ready) begin
                  sb.delete(0);
                  got++;
               end
            end
         end
         @(negedge Clk);
         cyc++;
      end
      out_ready = 1'b0;
      check("bins_delivered", got, 16);
      check("post_out_valid", ov0, 0);
      check("post_in_ready", ir0, 1);
   endtask

   initial begin
      Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      check("rst_in_ready", ir0, 1);
      check("rst_busy", bz0, 0);
      check("rst_out_valid", ov0, 0);
      check("rst_out_last", l0, 0);
      check("rst_overflow", of0, 0);

      // Impulse
      fill_x(0, 0);
      xr[0] = 1000;
      exp_all(0, 1000, 0);
      exp_all(1, 62, 0);
      exp_all(2, 1000, 0);
      exp_push();
      load_frame(1'b0, 1'b0);
      run_proc(1'b1);
      check("imp_overflow", of0, 0);
      unload(1'b0);

      // DC
      fill_x(100, 0);
      exp_all(0, 0, 0); er[0][0] = 1600;
      exp_all(1, 0, 0); er[1][0] = 100;
      exp_all(2, 0, 0); er[2][0] = 1600;
      exp_push();
      load_frame(1'b0, 1'b0);
      run_proc(1'b1);
      unload(1'b0);

      // Nyquist tone, forward then inverse
      for (int n = 0; n < 16; n++) begin
         xr[n] = (n % 2 == 0) ? 1000 : -1000;
         xi[n] = 0;
      end
      exp_all(0, 0, 0); er[0][8] = 16000;
      exp_all(1, 0, 0); er[1][8] = 1000;
      exp_all(2, 0, 0); er[2][8] = 16000;
      exp_push();
      load_frame(1'b0, 1'b0);
      run_proc(1'b1);
      unload(1'b0);
      exp_push();
      load_frame(1'b1, 1'b0);
      run_proc(1'b1);
      unload(1'b0);

      // Complex impulse under input gaps and output back-pressure
      fill_x(0, 0);
      xr[0] = 300;
      xi[0] = -200;
      exp_all(0, 300, -200);
      exp_all(1, 18, -13);
      exp_all(2, 300, -200);
      exp_push();
      load_frame(1'b0, 1'b1);
      run_proc(1'b1);
      unload(1'b1);

      // Full-scale DC saturates the 16-bit instance
      fill_x(32767, 0);
      exp_all(0, 0, 0); er[0][0] = 524272;
      exp_all(1, 0, 0); er[1][0] = 32767;
      exp_all(2, 0, 0); er[2][0] = 32767;
      exp_push();
      load_frame(1'b0, 1'b0);
      run_proc(1'b1);
      check("sat_ovf16", of2, 1);
      check("sat_ovf32", of0, 0);
      unload(1'b0);
      check("sat_ovf_sticky", of2, 1);

      // Zero frame clears the sticky flag on its first sample
      fill_x(0, 0);
      exp_all(0, 0, 0);
      exp_all(1, 0, 0);
      exp_all(2, 0, 0);
      exp_push();
      load_frame(1'b0, 1'b0);
      check("zero_ovf_clear", of2, 0);
      run_proc(1'b1);
      unload(1'b0);

      // Reset during pass 2, then a clean impulse frame
      fill_x(0, 0);
      xr[0] = 1000;
      load_frame(1'b0, 1'b0);
      repeat (40) @(negedge Clk);
      check("mid_busy", bz0, 1);
      Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      check("mrst_in_ready", ir0, 1);
      check("mrst_busy", bz0, 0);
      check("mrst_out_valid", ov0, 0);
      exp_all(0, 1000, 0);
      exp_all(1, 62, 0);
      exp_all(2, 1000, 0);
      exp_push();
      load_frame(1'b0, 1'b0);
      run_proc(1'b1);
      unload(1'b0);
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
